// File: rtl/icache_port_arbiter.sv
// icache_port_arbiter: shares the ICache request port between instruction fetches and CACHE ops,
// drains fetches before an op and drops responses of flushed fetches. Stats: ICACHE_ARB_STATS_EN.
module icache_port_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        fetch_req,
   input  logic [7:0]  fetch_index,
   input  logic [3:0]  fetch_offset,
   output logic        fetch_addr_ok,
   output logic        fetch_data_ok,
   output logic [31:0] fetch_rdata,
   input  logic        flush,
   input  logic        cop_req,
   input  logic [7:0]  cop_index,
   input  logic [2:0]  cop_op,
   output logic        cop_addr_ok,
   output logic        cop_done,
   output logic        icache_req,
   output logic        icache_is_op,
   output logic [7:0]  icache_index,
   output logic [3:0]  icache_offset,
   output logic [2:0]  icache_op,
   input  logic        icache_addr_ok,
   input  logic        icache_data_ok,
   input  logic [31:0] icache_rdata,
   output logic [31:0] stat_fetch_grants,
   output logic [31:0] stat_cop_stall,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers in the cycle icache_req & icache_addr_ok; a response
   // or op completion is the single cycle icache_data_ok is high. Nothing is held back.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      DRAIN    = 2'd2,
      COP_WAIT = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] outst_q, outst_d;
   logic [1:0] discard_q, discard_d;
   logic       room;
   logic       drive_fetch, drive_op;
   logic       fetch_acc, cop_acc, resp;

   assign room = 32'(outst_q) < MAX_OUTSTANDING;

   always_comb begin
      drive_fetch = 1'b0;
      drive_op    = 1'b0;
      case (state_q)
         IDLE: begin
            drive_op    = cop_req;
            drive_fetch = fetch_req & ~cop_req;
         end
         FETCH:   drive_fetch = fetch_req & ~cop_req & room;
         DRAIN:   drive_op    = cop_req & (outst_q == 2'd0) & (discard_q == 2'd0);
         default: ;
      endcase
      drive_fetch = drive_fetch & resetn;
      drive_op    = drive_op & resetn;
   end

   assign fetch_acc = drive_fetch & icache_addr_ok;
   assign cop_acc   = drive_op & icache_addr_ok;
   // Only fetch responses that some accepted request is still waiting for count.
   assign resp      = resetn & icache_data_ok & (state_q != COP_WAIT) & (outst_q != 2'd0);

   always_comb begin
      outst_d   = outst_q + {1'b0, fetch_acc} - {1'b0, resp};
      discard_d = discard_q;
      if (flush) begin
         discard_d = outst_d;
      end else if (resp && (discard_q != 2'd0)) begin
         discard_d = discard_q - 2'd1;
      end
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cop_acc)        state_d = COP_WAIT;
            else if (fetch_acc) state_d = FETCH;
         end
         FETCH: begin
            if (cop_req)                state_d = DRAIN;
            else if (outst_d == 2'd0)   state_d = IDLE;
         end
         DRAIN:    if (cop_acc) state_d = COP_WAIT;
         COP_WAIT: if (icache_data_ok) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         outst_q   <= 2'd0;
         discard_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   assign icache_req    = drive_fetch | drive_op;
   assign icache_is_op  = drive_op;
   assign icache_index  = drive_op ? cop_index : (drive_fetch ? fetch_index : 8'd0);
   assign icache_offset = drive_fetch ? fetch_offset : 4'd0;
   assign icache_op     = drive_op ? cop_op : 3'd0;
   assign fetch_addr_ok = fetch_acc;
   assign cop_addr_ok   = cop_acc;
   assign fetch_data_ok = resp & (discard_q == 2'd0) & ~flush;
   assign fetch_rdata   = resetn ? icache_rdata : 32'd0;
   assign cop_done      = resetn & (state_q == COP_WAIT) & icache_data_ok;
   assign dbg_state     = state_q;

`ifdef ICACHE_ARB_STATS_EN
   logic [31:0] stat_fetch_grants_q, stat_fetch_grants_d;
   logic [31:0] stat_cop_stall_q, stat_cop_stall_d;

   always_comb begin
      stat_fetch_grants_d = stat_fetch_grants_q + {31'd0, fetch_acc};
      stat_cop_stall_d    = stat_cop_stall_q + {31'd0, cop_req & ~cop_acc};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_fetch_grants_q <= 32'd0;
         stat_cop_stall_q    <= 32'd0;
      end else begin
         stat_fetch_grants_q <= stat_fetch_grants_d;
         stat_cop_stall_q    <= stat_cop_stall_d;
      end
   end

   assign stat_fetch_grants = stat_fetch_grants_q;
   assign stat_cop_stall    = stat_cop_stall_q;
`else
   assign stat_fetch_grants = 32'd0;
   assign stat_cop_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Directed bench for icache_port_arbiter: one instance with MAX_OUTSTANDING=2 and one with 3
// sharing the same stimulus; expected values are hand-computed per cycle.
module tb_icache_port_arbiter;

   logic        clk;
   logic        resetn;
   logic        fetch_req;
   logic [7:0]  fetch_index;
   logic [3:0]  fetch_offset;
   logic        flush;
   logic        cop_req;
   logic [7:0]  cop_index;
   logic [2:0]  cop_op;
   logic        icache_addr_ok;
   logic        icache_data_ok;
   logic [31:0] icache_rdata;

   logic        fetch_addr_ok, fetch_data_ok, cop_addr_ok, cop_done;
   logic [31:0] fetch_rdata, stat_fetch_grants, stat_cop_stall;
   logic        icache_req, icache_is_op;
   logic [7:0]  icache_index;
   logic [3:0]  icache_offset;
   logic [2:0]  icache_op;
   logic [1:0]  dbg_state;

   logic        b_fetch_addr_ok, b_fetch_data_ok, b_cop_addr_ok, b_cop_done;
   logic [31:0] b_fetch_rdata, b_stat_fetch_grants, b_stat_cop_stall;
   logic        b_icache_req, b_icache_is_op;
   logic [7:0]  b_icache_index;
   logic [3:0]  b_icache_offset;
   logic [2:0]  b_icache_op;
   logic [1:0]  b_dbg_state;

   logic [31:0] exp_q[$];
   int          n_vec;
   int          n_err;

`ifdef ICACHE_ARB_STATS_EN
   localparam logic [31:0] EXP_GRANTS = 32'd5;
   localparam logic [31:0] EXP_STALL  = 32'd3;
`else
   localparam logic [31:0] EXP_GRANTS = 32'd0;
   localparam logic [31:0] EXP_STALL  = 32'd0;
`endif

   icache_port_arbiter #(.MAX_OUTSTANDING(2)) u_dut (
      .clk(clk), .resetn(resetn),
      .fetch_req(fetch_req), .fetch_index(fetch_index), .fetch_offset(fetch_offset),
      .fetch_addr_ok(fetch_addr_ok), .fetch_data_ok(fetch_data_ok), .fetch_rdata(fetch_rdata),
      .flush(flush), .cop_req(cop_req), .cop_index(cop_index), .cop_op(cop_op),
      .cop_addr_ok(cop_addr_ok), .cop_done(cop_done),
      .icache_req(icache_req), .icache_is_op(icache_is_op), .icache_index(icache_index),
      .icache_offset(icache_offset), .icache_op(icache_op),
      .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok), .icache_rdata(icache_rdata),
      .stat_fetch_grants(stat_fetch_grants), .stat_cop_stall(stat_cop_stall), .dbg_state(dbg_state)
   );

   icache_port_arbiter #(.MAX_OUTSTANDING(3)) u_dut3 (
      .clk(clk), .resetn(resetn),
      .fetch_req(fetch_req), .fetch_index(fetch_index), .fetch_offset(fetch_offset),
      .fetch_addr_ok(b_fetch_addr_ok), .fetch_data_ok(b_fetch_data_ok), .fetch_rdata(b_fetch_rdata),
      .flush(flush), .cop_req(cop_req), .cop_index(cop_index), .cop_op(cop_op),
      .cop_addr_ok(b_cop_addr_ok), .cop_done(b_cop_done),
      .icache_req(b_icache_req), .icache_is_op(b_icache_is_op), .icache_index(b_icache_index),
      .icache_offset(b_icache_offset), .icache_op(b_icache_op),
      .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok), .icache_rdata(icache_rdata),
      .stat_fetch_grants(b_stat_fetch_grants), .stat_cop_stall(b_stat_cop_stall),
      .dbg_state(b_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_data(input string tag);
      check({tag, "_v"}, {31'd0, fetch_data_ok}, 32'd1);
      if (exp_q.size() > 0) check(tag, fetch_rdata, exp_q.pop_front());
      else check({tag, "_q"}, 32'd0, 32'd1);
   endtask

   task automatic clr();
      fetch_req      = 1'b0;
      fetch_index    = 8'd0;
      fetch_offset   = 4'd0;
      flush          = 1'b0;
      cop_req        = 1'b0;
      cop_index      = 8'd0;
      cop_op         = 3'd0;
      icache_addr_ok = 1'b0;
      icache_data_ok = 1'b0;
      icache_rdata   = 32'd0;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic do_reset();
      clr();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      clr();
      resetn = 1'b0;
      @(posedge clk);
      #1;

      // outputs held at 0 under reset even with every input active
      fetch_req = 1'b1; cop_req = 1'b1; icache_addr_ok = 1'b1; icache_data_ok = 1'b1;
      icache_rdata = 32'h1234_5678;
      sample();
      check("rst_req",   {31'd0, icache_req}, 32'd0);
      check("rst_fao",   {31'd0, fetch_addr_ok}, 32'd0);
      check("rst_cao",   {31'd0, cop_addr_ok}, 32'd0);
      check("rst_fdo",   {31'd0, fetch_data_ok}, 32'd0);
      check("rst_done",  {31'd0, cop_done}, 32'd0);
      check("rst_rdata", fetch_rdata, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      check("rst_stat",  stat_fetch_grants | stat_cop_stall, 32'd0);
      do_reset();

      // back-to-back fetches, response two cycles after acceptance
      exp_q.push_back(32'h2402_0001);
      exp_q.push_back(32'h2403_0002);
      exp_q.push_back(32'h2404_0003);
      fetch_req = 1'b1; fetch_index = 8'h10; fetch_offset = 4'h4; icache_addr_ok = 1'b1;
      sample();
      check("t1_acc0", {31'd0, fetch_addr_ok}, 32'd1);
      check("t1_isop", {31'd0, icache_is_op}, 32'd0);
      check("t1_idx",  {24'd0, icache_index}, 32'h10);
      check("t1_off",  {28'd0, icache_offset}, 32'h4);
      adv();
      fetch_req = 1'b1; fetch_index = 8'h11; icache_addr_ok = 1'b1;
      sample();
      check("t1_acc1", {31'd0, fetch_addr_ok}, 32'd1);
      adv();
      fetch_req = 1'b1; fetch_index = 8'h12; icache_addr_ok = 1'b1;
      icache_data_ok = 1'b1; icache_rdata = 32'h2402_0001;
      sample();
      check("t1_full_req", {31'd0, icache_req}, 32'd0);
      check("t1_full_ok",  {31'd0, fetch_addr_ok}, 32'd0);
      check_data("t1_d0");
      adv();
      fetch_req = 1'b1; fetch_index = 8'h12; icache_addr_ok = 1'b1;
      icache_data_ok = 1'b1; icache_rdata = 32'h2403_0002;
      sample();
      check("t1_acc2", {31'd0, fetch_addr_ok}, 32'd1);
      check_data("t1_d1");
      adv();
      adv();
      icache_data_ok = 1'b1; icache_rdata = 32'h2404_0003;
      sample();
      check_data("t1_d2");
      adv();
      sample();
      check("t1_idle", {30'd0, dbg_state}, 32'd0);

      // response coinciding with a flush is dropped
      do_reset();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      adv();
      flush = 1'b1; icache_data_ok = 1'b1; icache_rdata = 32'h0bad_0001;
      sample();
      check("tf_drop", {31'd0, fetch_data_ok}, 32'd0);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      sample();
      check("tf_acc", {31'd0, fetch_addr_ok}, 32'd1);
      adv();
      icache_data_ok = 1'b1; icache_rdata = 32'h600d_0001;
      sample();
      check("tf_fwd_v", {31'd0, fetch_data_ok}, 32'd1);
      check("tf_fwd",   fetch_rdata, 32'h600d_0001);

      // flush with 2 outstanding plus one accepted that cycle (MAX=3 instance)
      do_reset();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1; flush = 1'b1;
      sample();
      check("t2_acc_flush", {31'd0, b_fetch_addr_ok}, 32'd1);
      adv();
      for (int i = 0; i < 3; i++) begin
         icache_data_ok = 1'b1; icache_rdata = 32'h1111_0000 + 32'(i);
         sample();
         check($sformatf("t2_disc%0d", i), {31'd0, b_fetch_data_ok}, 32'd0);
         adv();
      end
      fetch_req = 1'b1; fetch_index = 8'h20; icache_addr_ok = 1'b1;
      sample();
      check("t2_acc4", {31'd0, b_fetch_addr_ok}, 32'd1);
      adv();
      icache_data_ok = 1'b1; icache_rdata = 32'hdead_beef;
      sample();
      check("t2_fwd_v", {31'd0, b_fetch_data_ok}, 32'd1);
      check("t2_fwd",   b_fetch_rdata, 32'hdead_beef);

      // cop_req with 2 fetches outstanding drains before the op goes out
      do_reset();
      fetch_req = 1'b1; fetch_index = 8'h30; icache_addr_ok = 1'b1;
      adv();
      fetch_req = 1'b1; fetch_index = 8'h31; icache_addr_ok = 1'b1;
      adv();
      fetch_req = 1'b1; cop_req = 1'b1; cop_index = 8'h55; cop_op = 3'd5; icache_addr_ok = 1'b1;
      sample();
      check("t3_c2_req", {31'd0, icache_req}, 32'd0);
      adv();
      fetch_req = 1'b1; cop_req = 1'b1; cop_index = 8'h55; cop_op = 3'd5; icache_addr_ok = 1'b1;
      icache_data_ok = 1'b1; icache_rdata = 32'h3030_0001;
      sample();
      check("t3_drain",  {30'd0, dbg_state}, 32'd2);
      check("t3_c3_req", {31'd0, icache_req}, 32'd0);
      check("t3_c3_fdo", {31'd0, fetch_data_ok}, 32'd1);
      adv();
      fetch_req = 1'b1; cop_req = 1'b1; cop_index = 8'h55; cop_op = 3'd5; icache_addr_ok = 1'b1;
      icache_data_ok = 1'b1; icache_rdata = 32'h3030_0002;
      sample();
      check("t3_c4_req", {31'd0, icache_req}, 32'd0);
      check("t3_c4_fdo", {31'd0, fetch_data_ok}, 32'd1);
      adv();
      fetch_req = 1'b1; cop_req = 1'b1; cop_index = 8'h55; cop_op = 3'd5; icache_addr_ok = 1'b1;
      sample();
      check("t3_op_req", {31'd0, icache_req}, 32'd1);
      check("t3_op_isop", {31'd0, icache_is_op}, 32'd1);
      check("t3_op_idx", {24'd0, icache_index}, 32'h55);
      check("t3_op_op",  {29'd0, icache_op}, 32'd5);
      check("t3_op_off", {28'd0, icache_offset}, 32'd0);
      check("t3_op_cao", {31'd0, cop_addr_ok}, 32'd1);
      check("t3_op_fao", {31'd0, fetch_addr_ok}, 32'd0);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      sample();
      check("t3_wait",     {30'd0, dbg_state}, 32'd3);
      check("t3_wait_req", {31'd0, icache_req}, 32'd0);
      check("t3_stall",    stat_cop_stall, EXP_STALL);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1; icache_data_ok = 1'b1;
      sample();
      check("t3_done", {31'd0, cop_done}, 32'd1);
      check("t3_done_fdo", {31'd0, fetch_data_ok}, 32'd0);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      sample();
      check("t3_nodone", {31'd0, cop_done}, 32'd0);
      check("t3_acc_after", {31'd0, fetch_addr_ok}, 32'd1);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      adv();
      icache_data_ok = 1'b1; icache_rdata = 32'h4444_0001;
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      adv();
      sample();
      check("t3_grants", stat_fetch_grants, EXP_GRANTS);

      // cop and fetch together in IDLE: op first, fetch waits for IDLE
      do_reset();
      fetch_req = 1'b1; cop_req = 1'b1; cop_index = 8'h66; cop_op = 3'd1;
      sample();
      check("t4_hold_isop", {31'd0, icache_is_op}, 32'd1);
      check("t4_hold_cao",  {31'd0, cop_addr_ok}, 32'd0);
      adv();
      fetch_req = 1'b1; cop_req = 1'b1; cop_index = 8'h66; cop_op = 3'd1; icache_addr_ok = 1'b1;
      sample();
      check("t4_cao", {31'd0, cop_addr_ok}, 32'd1);
      check("t4_fao", {31'd0, fetch_addr_ok}, 32'd0);
      check("t4_idx", {24'd0, icache_index}, 32'h66);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      sample();
      check("t4_wait_fao", {31'd0, fetch_addr_ok}, 32'd0);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1; icache_data_ok = 1'b1;
      sample();
      check("t4_done", {31'd0, cop_done}, 32'd1);
      check("t4_done_fao", {31'd0, fetch_addr_ok}, 32'd0);
      adv();
      fetch_req = 1'b1; icache_addr_ok = 1'b1;
      sample();
      check("t4_fetch", {31'd0, fetch_addr_ok}, 32'd1);

      // reset dropped asynchronously in COP_WAIT, then a stray response
      do_reset();
      cop_req = 1'b1; icache_addr_ok = 1'b1;
      adv();
      sample();
      check("t5_wait", {30'd0, dbg_state}, 32'd3);
      adv();
      resetn = 1'b0;
      fetch_req = 1'b1; cop_req = 1'b1; icache_addr_ok = 1'b1; icache_data_ok = 1'b1;
      icache_rdata = 32'hcafe_f00d;
      #1;
      check("t5_req",   {31'd0, icache_req}, 32'd0);
      check("t5_done",  {31'd0, cop_done}, 32'd0);
      check("t5_fdo",   {31'd0, fetch_data_ok}, 32'd0);
      check("t5_cao",   {31'd0, cop_addr_ok}, 32'd0);
      check("t5_rdata", fetch_rdata, 32'd0);
      check("t5_state", {30'd0, dbg_state}, 32'd0);
      adv();
      resetn = 1'b1;
      icache_data_ok = 1'b1; icache_rdata = 32'hcafe_f00d;
      sample();
      check("t5_stray_fdo",  {31'd0, fetch_data_ok}, 32'd0);
      check("t5_stray_done", {31'd0, cop_done}, 32'd0);
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
